cmv300_sensor_emu: RTL
======================

Name: cmv300_sensor_emu

Overview:
Synthesizable CMV300 image-sensor emulator: the transmit end of the CMV300 control/data interface. Accepts sys_res/frame_req from the acquisition controller and drives clk_out, 10-bit pixel data, and fval/lval/dval exactly as the sensor would. Used for sensor-less FPGA bring-up, loopback testing of the capture/FIFO/USB path, and simulation benches. Output pixels are generated test patterns.

Parameters:
H_ACTIVE, 648, active pixels per line (dval high cycles per line)
V_ACTIVE, 488, active lines per frame
H_BLANK, 32, idle cycles between lines (lval/dval low, fval high); minimum 1
EXP_CYCLES, 100, exposure cycles after frame_req accepted; minimum 1
FOT_CYCLES, 64, frame-overhead cycles between exposure end and first line; minimum 1

Ports:
i_clk  in  1  emulated sensor clock (driven from controller clk_in); all logic on posedge
i_rst  in  1  asynchronous active-high reset
i_sys_res  in  1  sensor reset, active-low (sys_res_n semantics), sampled synchronously
i_frame_req  in  1  frame request; sampled high at posedge starts a frame from S_IDLE
i_pattern  in  2  pattern select, sampled at frame accept, held for the frame
o_clk_out  out  1  forwarded clock, equals i_clk; data changes on posedge, receiver samples on negedge
o_data  out  10  pixel data
o_fval  out  1  frame valid
o_lval  out  1  line valid
o_dval  out  1  data valid (identical to o_lval, separate pin for interface fidelity)
o_busy  out  1  high in any state other than S_IDLE and S_SYSRES
o_frame_done  out  1  one-cycle pulse after last pixel of a frame
o_frame_count  out  16  completed frames, wraps 0xFFFF->0
o_req_dropped  out  16  frame_req pulses ignored while busy, saturates at 0xFFFF

Behaviour:
- Async reset: state=S_SYSRES; all outputs 0 except o_clk_out (follows i_clk); counters 0.
- States: S_SYSRES, S_IDLE, S_EXPOSE, S_FOT, S_LINE, S_HBLANK.
- S_SYSRES: held while i_sys_res=0; on i_sys_res=1 -> S_IDLE next edge.
- i_sys_res=0 in any state: next edge -> S_SYSRES, o_fval/o_lval/o_dval/o_data=0, no o_frame_done, o_frame_count unchanged (mid-frame abort).
- S_IDLE: i_frame_req=1 at edge -> latch i_pattern, clear row/col/cycle counters, -> S_EXPOSE.
- S_EXPOSE: EXP_CYCLES cycles, then -> S_FOT. S_FOT: FOT_CYCLES cycles, then -> S_LINE with o_fval=1.
- Latency: frame_req sampled at edge k -> first o_dval=1 registered at edge k+EXP_CYCLES+FOT_CYCLES+1.
- S_LINE: o_lval=o_dval=1, o_data=pattern(row,col), col 0..H_ACTIVE-1 one per cycle. After col H_ACTIVE-1: if row<V_ACTIVE-1 -> S_HBLANK (row+1, col=0); else -> S_IDLE with o_fval=0, o_frame_done=1 one cycle, o_frame_count+1.
- S_HBLANK: H_BLANK cycles, o_fval=1, o_lval=o_dval=0, o_data=0; then -> S_LINE.
- o_data=0 whenever o_dval=0.
- Total dval cycles per frame exactly H_ACTIVE*V_ACTIVE (316224 at defaults).
- Patterns (col 10b, row 9b, index 19b):
  0: running pixel index mod 1024 (index restarts at 0 each frame);
  1: (row+col) truncated to 10 bits;
  2: constant 10'h2AA;
  3: checkerboard, (row[3]^col[3]) ? 10'h3FF : 10'h000.
- i_frame_req while o_busy=1 (including the frame_done cycle's state): ignored, o_req_dropped+1 per cycle sampled high, saturating. Requests are not queued.
- i_frame_req on the same edge that enters S_IDLE from S_LINE: ignored and counted (state was S_LINE at sample).
- i_pattern changes mid-frame: no effect until next frame accept.

Test Plan:
- Reset/sys_res: assert i_rst async mid-cycle -> all outputs 0 immediately; release with i_sys_res=0 -> stays S_SYSRES, o_busy=0; i_sys_res=1 -> S_IDLE next edge.
- Small frame (H_ACTIVE=8,V_ACTIVE=4,H_BLANK=3,EXP=5,FOT=2), pattern 0, 1-cycle frame_req at edge k -> first dval at edge k+8; 4 lines of 8 dval cycles, data 0..31, 3 idle cycles between lines, o_frame_done one cycle, o_frame_count=1.
- Patterns 1/2/3 on same small frame -> row 2 col 5 gives 7, 0x2AA, 0x000; with H_ACTIVE=16 row 0 col 8 pattern 3 gives 0x3FF.
- Defaults with controller model: one frame -> exactly 316224 dval cycles, fval high from first to last pixel, frame_done once.
- frame_req asserted for 3 cycles, then once more mid-frame -> one frame only, o_req_dropped=3.
- i_sys_res pulsed low during line 2 -> fval/lval/dval low next edge, no frame_done, o_frame_count unchanged; new frame_req after release produces a full correct frame.

Source files
------------

// File: rtl/cmv300_sensor_emu_if.sv
// Control/data bus between the acquisition controller (master) and the sensor emulator (slave).
interface cmv300_sensor_emu_if;
  logic        i_sys_res;
  logic        i_frame_req;
  logic [1:0]  i_pattern;
  logic        o_clk_out;
  logic [9:0]  o_data;
  logic        o_fval;
  logic        o_lval;
  logic        o_dval;
  logic        o_busy;
  logic        o_frame_done;
  logic [15:0] o_frame_count;
  logic [15:0] o_req_dropped;

  modport master (
    output i_sys_res, i_frame_req, i_pattern,
    input  o_clk_out, o_data, o_fval, o_lval, o_dval, o_busy,
           o_frame_done, o_frame_count, o_req_dropped
  );

  modport slave (
    input  i_sys_res, i_frame_req, i_pattern,
    output o_clk_out, o_data, o_fval, o_lval, o_dval, o_busy,
           o_frame_done, o_frame_count, o_req_dropped
  );
endinterface

// File: rtl/cmv300_sensor_emu.sv
// CMV300 sensor emulator: exposure/FOT sequencing, line/blank timing and test-pattern pixels.
module cmv300_sensor_emu #(
  parameter int H_ACTIVE   = 648,
  parameter int V_ACTIVE   = 488,
  parameter int H_BLANK    = 32,
  parameter int EXP_CYCLES = 100,
  parameter int FOT_CYCLES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cmv300_sensor_emu_if.slave   bus
);

  localparam logic [2:0] S_SYSRES = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_EXPOSE = 3'd2;
  localparam logic [2:0] S_FOT    = 3'd3;
  localparam logic [2:0] S_LINE   = 3'd4;
  localparam logic [2:0] S_HBLANK = 3'd5;

  localparam logic [9:0]  COL_LAST = 10'(H_ACTIVE - 1);
  localparam logic [8:0]  ROW_LAST = 9'(V_ACTIVE - 1);
  localparam logic [15:0] EXP_LAST = 16'(EXP_CYCLES - 1);
  localparam logic [15:0] FOT_LAST = 16'(FOT_CYCLES - 1);
  localparam logic [15:0] HB_LAST  = 16'(H_BLANK - 1);

  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [9:0]  col_q, col_d;
  logic [8:0]  row_q, row_d;
  logic [18:0] idx_q, idx_d;
  logic [1:0]  pat_q, pat_d;
  logic [9:0]  data_q, data_d;
  logic        fval_q, fval_d;
  logic        lval_q, lval_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic [15:0] drop_q, drop_d;
  logic [9:0]  pix;
  logic        busy;

  assign busy = (state_q != S_IDLE) && (state_q != S_SYSRES);

  always_comb begin
    pix = 10'h000;
    case (pat_q)
      2'd0: pix = idx_q[9:0];
      2'd1: pix = col_q + 10'(row_q);
      2'd2: pix = 10'h2AA;
      2'd3: pix = {10{row_q[3] ^ col_q[3]}};
      default: pix = 10'h000;
    endcase
  end

  // Outputs are registered from the current state, so the pixel bus trails the
  // sequencer by one cycle; frame_done trails the last pixel by one more.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    col_d   = col_q;
    row_d   = row_q;
    idx_d   = idx_q;
    pat_d   = pat_q;
    fcnt_d  = fcnt_q;
    drop_d  = drop_q;
    data_d  = 10'h000;
    fval_d  = 1'b0;
    lval_d  = 1'b0;
    last_d  = 1'b0;
    done_d  = 1'b0;

    if (busy && bus.i_frame_req && (drop_q != 16'hFFFF))
      drop_d = drop_q + 16'd1;

    if (!bus.i_sys_res) begin
      state_d = S_SYSRES;
    end else begin
      if (last_q) begin
        done_d = 1'b1;
        fcnt_d = fcnt_q + 16'd1;
      end
      case (state_q)
        S_SYSRES: state_d = S_IDLE;
        S_IDLE: begin
          if (bus.i_frame_req) begin
            pat_d   = bus.i_pattern;
            cnt_d   = 16'd0;
            col_d   = 10'd0;
            row_d   = 9'd0;
            idx_d   = 19'd0;
            state_d = S_EXPOSE;
          end
        end
        S_EXPOSE: begin
          if (cnt_q == EXP_LAST) begin
            cnt_d   = 16'd0;
            state_d = S_FOT;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_FOT: begin
          if (cnt_q == FOT_LAST) begin
            cnt_d   = 16'd0;
            state_d = S_LINE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        S_LINE: begin
          fval_d = 1'b1;
          lval_d = 1'b1;
          data_d = pix;
          idx_d  = idx_q + 19'd1;
          if (col_q == COL_LAST) begin
            col_d = 10'd0;
            if (row_q == ROW_LAST) begin
              last_d  = 1'b1;
              state_d = S_IDLE;
            end else begin
              row_d   = row_q + 9'd1;
              cnt_d   = 16'd0;
              state_d = S_HBLANK;
            end
          end else begin
            col_d = col_q + 10'd1;
          end
        end
        S_HBLANK: begin
          fval_d = 1'b1;
          if (cnt_q == HB_LAST) begin
            cnt_d   = 16'd0;
            state_d = S_LINE;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: state_d = S_SYSRES;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_SYSRES;
      cnt_q   <= 16'd0;
      col_q   <= 10'd0;
      row_q   <= 9'd0;
      idx_q   <= 19'd0;
      pat_q   <= 2'd0;
      data_q  <= 10'd0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      fcnt_q  <= 16'd0;
      drop_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      pat_q   <= pat_d;
      data_q  <= data_d;
      fval_q  <= fval_d;
      lval_q  <= lval_d;
      last_q  <= last_d;
      done_q  <= done_d;
      fcnt_q  <= fcnt_d;
      drop_q  <= drop_d;
    end
  end

  assign bus.o_clk_out     = i_clk;
  assign bus.o_data        = data_q;
  assign bus.o_fval        = fval_q;
  assign bus.o_lval        = lval_q;
  assign bus.o_dval        = lval_q;
  assign bus.o_busy        = busy;
  assign bus.o_frame_done  = done_q;
  assign bus.o_frame_count = fcnt_q;
  assign bus.o_req_dropped = drop_q;

endmodule
